// File: rtl/duc_ctrl_pkg.sv
// Shared definitions for the DUC transmit scheduler: FSM states, DUC command
// words and local-bus address defaults.
package duc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_DATA  = 4'd2,
    ST_PAD   = 4'd3,
    ST_GAP   = 4'd4,
    ST_END   = 4'd5,
    ST_TRIG  = 4'd6,
    ST_WAIT  = 4'd7,
    ST_DRAIN = 4'd8,
    ST_ABORT = 4'd9
  } state_e;

  localparam logic [31:0] CMD_DOWN_START = 32'h0000_5555;
  localparam logic [31:0] CMD_DOWN_END   = 32'h0000_8888;
  localparam logic [31:0] CMD_DOWN_TRIG  = 32'h0000_FFFF;
  localparam logic [31:0] CMD_CLEAR      = 32'h0000_0000;

  localparam logic [13:0] DEF_START_ADDR  = 14'd12000;
  localparam logic [13:0] DEF_CMD_ADDR    = 14'd16000;
  localparam int          DEF_FRAME_WORDS = 3840;
  localparam logic [31:0] DEF_TIMEOUT_CYC = 32'd5000000;

  localparam int WCNT_W = 12;
  // The command register only reflects the TRIG write a couple of cycles later.
  localparam logic [31:0] POLL_DLY = 32'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the channel that did not hold
// the last completed grant wins; last_grant resets to 1 so ch0 wins first.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_ch,
  output logic       gnt_vld,
  output logic       gnt_ch
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_vld = |req;
    gnt_ch  = (req == 2'b11) ? ~last_q : req[1];
    last_d  = upd ? upd_ch : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/duc_tx_sched.sv
// Local-bus master that writes one frame from ch0/ch1 into DUC baseband RAM,
// runs the download/trigger command sequence and polls for completion.
module duc_tx_sched
  import duc_ctrl_pkg::*;
#(
  parameter logic [13:0] START_ADDR  = DEF_START_ADDR,
  parameter int          FRAME_WORDS = DEF_FRAME_WORDS,
  parameter logic [13:0] CMD_ADDR    = DEF_CMD_ADDR,
  parameter logic [31:0] TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic        rst_n,
  input  logic        lbs_clk,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic [31:0] s0_tdata,
  input  logic        s0_tlast,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic [31:0] s1_tdata,
  input  logic        s1_tlast,
  output logic        m_lbs_we,
  output logic [13:0] m_lbs_addr,
  output logic [31:0] m_lbs_din,
  input  logic [31:0] duc_cmd_register,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        busy,
  output logic        owner
);

  localparam logic [WCNT_W-1:0] LAST_W = WCNT_W'(FRAME_WORDS - 1);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [31:0]         tcnt_q, tcnt_d;
  logic                eflag_q, eflag_d;
  logic                we_q, we_d;
  logic [13:0]         addr_q, addr_d;
  logic [31:0]         din_q, din_d;
  logic [1:0]          tready_q, tready_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic                busy_q, busy_d;

  logic                gnt_vld;
  logic                gnt_ch;
  logic                arb_upd;
  logic                sel_valid;
  logic [31:0]         sel_data;
  logic                sel_last;
  logic                accept;
  logic [13:0]         ram_addr;

  rr_arb2 u_arb (
    .clk     (lbs_clk),
    .rst_n   (rst_n),
    .req     ({s1_tvalid, s0_tvalid}),
    .upd     (arb_upd),
    .upd_ch  (owner_q),
    .gnt_vld (gnt_vld),
    .gnt_ch  (gnt_ch)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    eflag_d  = eflag_q;
    we_d     = 1'b0;
    addr_d   = '0;
    din_d    = '0;
    done_d   = '0;
    err_d    = '0;
    arb_upd  = 1'b0;

    sel_valid = owner_q ? s1_tvalid : s0_tvalid;
    sel_data  = owner_q ? s1_tdata  : s0_tdata;
    sel_last  = owner_q ? s1_tlast  : s0_tlast;
    accept    = sel_valid & tready_q[owner_q];
    ram_addr  = START_ADDR + {2'b00, wcnt_q};

    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_ch;
          wcnt_d  = '0;
          eflag_d = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        we_d    = 1'b1;
        addr_d  = CMD_ADDR;
        din_d   = CMD_DOWN_START;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = ram_addr;
          din_d  = sel_data;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_W) begin
            if (sel_last) begin
              state_d = ST_GAP;
            end else begin
              eflag_d = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (sel_last) begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        we_d   = 1'b1;
        addr_d = ram_addr;
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == LAST_W) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // In-range address with we low drops the DUC's RAM write enable.
        addr_d  = START_ADDR;
        state_d = ST_END;
      end
      ST_END: begin
        we_d    = 1'b1;
        addr_d  = CMD_ADDR;
        din_d   = CMD_DOWN_END;
        state_d = eflag_q ? ST_ABORT : ST_TRIG;
      end
      ST_TRIG: begin
        we_d    = 1'b1;
        addr_d  = CMD_ADDR;
        din_d   = CMD_DOWN_TRIG;
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if ((tcnt_q >= POLL_DLY) && (duc_cmd_register == 32'd0)) begin
          done_d[owner_q] = 1'b1;
          arb_upd         = 1'b1;
          state_d         = ST_IDLE;
        end else if (tcnt_q == TIMEOUT_CYC - 32'd1) begin
          state_d = ST_ABORT;
        end else begin
          tcnt_d = tcnt_q + 32'd1;
        end
      end
      ST_DRAIN: begin
        if (accept && sel_last) begin
          state_d = ST_GAP;
        end
      end
      ST_ABORT: begin
        we_d           = 1'b1;
        addr_d         = CMD_ADDR;
        din_d          = CMD_CLEAR;
        err_d[owner_q] = 1'b1;
        arb_upd        = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tready is registered, so it is driven from the state being entered.
    tready_d = '0;
    if ((state_d == ST_DATA) || (state_d == ST_DRAIN)) begin
      tready_d[owner_d] = 1'b1;
    end
    busy_d = (state_q != ST_IDLE);
  end

  always_ff @(posedge lbs_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      wcnt_q   <= '0;
      tcnt_q   <= '0;
      eflag_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      tready_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      eflag_q  <= eflag_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      tready_q <= tready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign s0_tready  = tready_q[0];
  assign s1_tready  = tready_q[1];
  assign m_lbs_we   = we_q;
  assign m_lbs_addr = addr_q;
  assign m_lbs_din  = din_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_duc_tx_sched.sv
// Self-checking bench for duc_tx_sched: a DUC command-register model, frame
// drivers, a write-stream scoreboard and a frame-level reference model.
module tb_duc_tx_sched;

  localparam logic [13:0] START_A = 14'd12000;
  localparam logic [13:0] CMD_A   = 14'd16000;
  localparam int          FW      = 3840;
  localparam int          TMO     = 1000;
  localparam int          CLR_DLY = 100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic        s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic [31:0] s0_tdata = '0, s1_tdata = '0;
  logic        s0_tready, s1_tready;
  logic        m_we;
  logic [13:0] m_addr;
  logic [31:0] m_din;
  logic [31:0] duc_reg = '0;
  logic [1:0]  done, err;
  logic        busy, owner;

  always #5 clk = ~clk;

  duc_tx_sched #(
    .START_ADDR  (START_A),
    .FRAME_WORDS (FW),
    .CMD_ADDR    (CMD_A),
    .TIMEOUT_CYC (32'(TMO))
  ) dut (
    .rst_n            (rst_n),
    .lbs_clk          (clk),
    .s0_tvalid        (s0_tvalid),
    .s0_tready        (s0_tready),
    .s0_tdata         (s0_tdata),
    .s0_tlast         (s0_tlast),
    .s1_tvalid        (s1_tvalid),
    .s1_tready        (s1_tready),
    .s1_tdata         (s1_tdata),
    .s1_tlast         (s1_tlast),
    .m_lbs_we         (m_we),
    .m_lbs_addr       (m_addr),
    .m_lbs_din        (m_din),
    .duc_cmd_register (duc_reg),
    .done             (done),
    .err              (err),
    .busy             (busy),
    .owner            (owner)
  );

  // ---------------- scoreboard state ----------------
  logic [45:0] exp_q[$];
  logic [45:0] got_q[$];
  int          seq_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0, clr_cnt = 0;
  int cyc_ffff, cyc_8888, cyc_zero, cyc_done, last_ram_cyc;
  int n_pulse, viol;
  logic [1:0] done_acc, err_acc;
  logic busy_at_err, busy_after_err, err_pend, owner_at_start;
  bit hold = 0, single = 0, drv_abort = 0;
  int other = 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    seq_q.delete();
    exp_q.delete();
    cyc_ffff = -1; cyc_8888 = -1; cyc_zero = -1; cyc_done = -1; last_ram_cyc = -1;
    n_pulse = 0; viol = 0; done_acc = '0; err_acc = '0;
    busy_at_err = 1'b0; busy_after_err = 1'b1; err_pend = 1'b0; owner_at_start = 1'bx;
  endtask

  // DUC model: the command register takes every command write; after a
  // trigger it reads back 0 once the frame has been sent (unless held busy).
  always @(negedge clk) begin
    cyc++;
    if (clr_cnt > 0) begin
      clr_cnt--;
      if (clr_cnt == 0 && !hold) duc_reg = 32'd0;
    end
    if (rst_n && m_we) begin
      got_q.push_back({m_addr, m_din});
      if (m_addr == CMD_A) begin
        duc_reg = m_din;
        if (m_din == 32'h5555) owner_at_start = owner;
        if (m_din == 32'hFFFF) begin cyc_ffff = cyc; clr_cnt = CLR_DLY; end
        if (m_din == 32'h8888) cyc_8888 = cyc;
        if (m_din == 32'h0) cyc_zero = cyc;
      end else begin
        last_ram_cyc = cyc;
      end
    end
    if (err_pend) begin busy_after_err = busy; err_pend = 1'b0; end
    if (done != 2'b00) begin done_acc |= done; n_pulse++; cyc_done = cyc; seq_q.push_back(int'(done[1])); end
    if (err != 2'b00) begin err_acc |= err; n_pulse++; busy_at_err = busy; err_pend = 1'b1; end
    if ((s0_tready && s1_tready) || (single && (other == 1 ? s1_tready : s0_tready))) viol++;
  end

  // ---------------- reference model ----------------
  // Expected bus writes for one frame of len words (word i = base+i).
  task automatic model(input int len, input logic [31:0] base, input bit hold_i);
    exp_q.push_back({CMD_A, 32'h5555});
    for (int i = 0; i < FW; i++)
      exp_q.push_back({START_A + 14'(i), (i < len) ? base + 32'(i) : 32'd0});
    exp_q.push_back({CMD_A, 32'h8888});
    if (len > FW) begin
      exp_q.push_back({CMD_A, 32'h0});
    end else begin
      exp_q.push_back({CMD_A, 32'hFFFF});
      if (hold_i) exp_q.push_back({CMD_A, 32'h0});
    end
  endtask

  task automatic compare_writes(input string name);
    int bad = -1;
    n_chk++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      n_fail++;
      if (bad >= 0)
        $display("FAIL %s.writes: idx %0d got addr %0d data %0h expected addr %0d data %0h",
                 name, bad, got_q[bad][45:32], got_q[bad][31:0], exp_q[bad][45:32], exp_q[bad][31:0]);
      else
        $display("FAIL %s.writes: got %0d writes expected %0d", name, got_q.size(), exp_q.size());
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int ch, input logic v, input logic [31:0] d, input logic l);
    if (ch == 0) begin s0_tvalid = v; s0_tdata = d; s0_tlast = l; end
    else         begin s1_tvalid = v; s1_tdata = d; s1_tlast = l; end
  endtask

  task automatic send_frame(input int ch, input int len, input logic [31:0] base, input int bub);
    int idx = 0;
    int budget = 0;
    while (idx < len && !drv_abort) begin
      @(negedge clk);
      budget++;
      if (budget > 30000) begin
        check($sformatf("drv%0d.budget", ch), 64'(idx), 64'(len));
        break;
      end
      if (int'($urandom_range(99, 0)) < bub) begin
        drive(ch, 1'b0, 32'd0, 1'b0);
      end else begin
        drive(ch, 1'b1, base + 32'(idx), idx == len - 1);
        if (ch == 0 ? s0_tready : s1_tready) idx++;
      end
    end
    @(negedge clk);
    drive(ch, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic wait_pulses(input int n);
    int b = 0;
    while (n_pulse < n && b < 9000) begin @(negedge clk); b++; end
    repeat (5) @(negedge clk);
  endtask

  task automatic run_case(input int ch, input int len, input logic [31:0] base, input int bub,
                          input bit hold_i, input logic [1:0] exp_done, input logic [1:0] exp_err,
                          input string tag);
    clear_mon();
    hold = hold_i; single = 1; other = 1 - ch;
    model(len, base, hold_i);
    send_frame(ch, len, base, bub);
    wait_pulses(1);
    compare_writes(tag);
    check({tag, ".owner"}, owner_at_start, 64'(ch));
    check({tag, ".done"}, done_acc, exp_done);
    check({tag, ".err"}, err_acc, exp_err);
    check({tag, ".pulses"}, 64'(n_pulse), 64'd1);
    check({tag, ".tready_other"}, 64'(viol), 64'd0);
    if (len <= FW) check({tag, ".gap"}, 64'(cyc_8888 - last_ram_cyc), 64'd2);
    if (exp_done != 2'b00) check({tag, ".done_lat"}, 64'(cyc_done - cyc_ffff), 64'(CLR_DLY + 1));
    if (hold_i) begin
      check({tag, ".wait_cycles"}, 64'(cyc_zero - cyc_ffff - 1), 64'(TMO));
      check({tag, ".busy_at_err"}, busy_at_err, 64'd1);
      check({tag, ".busy_after_err"}, busy_after_err, 64'd0);
    end
  endtask

  typedef struct {
    int          ch;
    int          len;
    logic [31:0] base;
    int          bub;
    bit          hold;
    logic [1:0]  exp_done;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[4];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{0, FW,      32'h0,         0, 1'b0, 2'b01, 2'b00};
    vecs[1] = '{1, 10,      32'h0000_0100, 0, 1'b0, 2'b10, 2'b00};
    vecs[2] = '{0, FW+160,  32'h0,        10, 1'b0, 2'b00, 2'b01};
    vecs[3] = '{1, 3,       32'h00C0_0000, 0, 1'b1, 2'b00, 2'b10};

    clear_mon();
    repeat (3) @(negedge clk);
    check("reset.outs", {m_we, m_addr, m_din, done, err, busy, owner, s0_tready, s1_tready}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle.busy", busy, 64'd0);

    // Simultaneous requests straight after reset: ch0 first, then ch1.
    clear_mon(); single = 0; hold = 0;
    model(5, 32'hA000_0000, 0);
    model(5, 32'hB000_0000, 0);
    fork
      send_frame(0, 5, 32'hA000_0000, 0);
      send_frame(1, 5, 32'hB000_0000, 0);
    join
    wait_pulses(2);
    compare_writes("tie1");
    check("tie1.order", {32'(seq_q.size()), 16'(seq_q[0]), 16'(seq_q[1])}, {32'd2, 16'd0, 16'd1});

    // ch0 keeps requesting while ch1 waits: grants must alternate 0,1,0.
    clear_mon();
    model(4, 32'hC000_0000, 0);
    model(6, 32'hD000_0000, 0);
    model(4, 32'hC100_0000, 0);
    fork
      begin
        send_frame(0, 4, 32'hC000_0000, 0);
        send_frame(0, 4, 32'hC100_0000, 0);
      end
      send_frame(1, 6, 32'hD000_0000, 0);
    join
    wait_pulses(3);
    compare_writes("tie2");
    check("tie2.order", {32'(seq_q.size()), 8'(seq_q[0]), 8'(seq_q[1]), 8'(seq_q[2])},
          {32'd3, 8'd0, 8'd1, 8'd0});

    for (int v = 0; v < 4; v++)
      run_case(vecs[v].ch, vecs[v].len, vecs[v].base, vecs[v].bub, vecs[v].hold,
               vecs[v].exp_done, vecs[v].exp_err, $sformatf("vec%0d", v));

    for (int r = 0; r < 4; r++) begin
      int ch, len;
      logic [1:0] ed, ee;
      ch  = int'($urandom_range(1, 0));
      len = (r == 3) ? int'($urandom_range(FW + 3, FW - 2)) : int'($urandom_range(40, 1));
      ed  = (len <= FW) ? (2'b01 << ch) : 2'b00;
      ee  = (len <= FW) ? 2'b00 : (2'b01 << ch);
      run_case(ch, len, $urandom, int'($urandom_range(50, 0)), 1'b0, ed, ee, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of DATA, then a clean ch1 frame.
    clear_mon(); single = 1; other = 1; hold = 0; drv_abort = 0;
    fork
      send_frame(0, FW, 32'h0, 0);
      begin
        int b = 0;
        while (got_q.size() < 501 && b < 3000) begin @(negedge clk); b++; end
        check("rst.busy_before", busy, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst.outs", {m_we, m_addr, m_din, done, err, busy, owner, s0_tready, s1_tready}, 64'd0);
        drv_abort = 1;
      end
    join
    drv_abort = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_case(1, 7, 32'h7700_0000, 20, 1'b0, 2'b10, 2'b00, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #990000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
